counter_seq_ctrl: RTL and testbench

Sequencing controller for the board-level event counter driven from the push-buttons. It takes single-cycle key-edge pulses and the pressed-key level from the edge detectors. It owns the WIDTH-bit count register, which feeds LEDR. It adds single-step, hold-to-auto-repeat, free-run, clear and parallel load, all timed from an internal prescaled tick.

---
 rtl/counter_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Push-button event counter sequencer: single step, hold-to-repeat, free-run,
// clear and parallel load, all paced by a free-running prescaled tick.
module counter_seq_ctrl #(
   parameter int WIDTH        = 18,
   parameter int TICK_DIV     = 50000,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100,
   parameter int RUN_RATE     = 250
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_pulse,
   input  logic             step_level,
   input  logic             run_toggle,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   output logic [WIDTH-1:0] count,
   output logic             upd_pulse,
   output logic             wrap,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   localparam int PW    = $clog2(TICK_DIV);
   localparam int MAX_A = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int MAX_T = (MAX_A > RUN_RATE) ? MAX_A : RUN_RATE;
   localparam int TW    = $clog2(MAX_T + 1);

   logic [PW-1:0]    r_presc;
   logic [TW-1:0]    r_timer;
   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_upd;
   logic             r_wrap;

   logic             w_tick;
   logic [TW-1:0]    w_timer_inc;
   state_t           w_state_nxt;
   logic [TW-1:0]    w_timer_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_upd_val;
   logic             w_do_upd;
   logic             w_wrap;

   assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
   assign w_timer_inc = r_timer + TW'(1);
   assign w_upd_val   = dir ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
   assign w_wrap      = dir ? (r_count == '0) : (r_count == '1);

   // One priority chain: clear, load and run_toggle each swallow every lower-priority event.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_count_nxt = r_count;
      w_do_upd    = 1'b0;
      if (clear) begin
         w_count_nxt = '0;
         w_state_nxt = ST_IDLE;
         w_timer_nxt = '0;
      end else if (load) begin
         w_count_nxt = load_val;
      end else if (run_toggle) begin
         w_state_nxt = (r_state == ST_RUN) ? ST_IDLE : ST_RUN;
         w_timer_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (step_pulse) begin
                  w_do_upd    = 1'b1;
                  w_state_nxt = ST_HOLD;
                  w_timer_nxt = '0;
               end
            end
            ST_HOLD: begin
               if (!step_level) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_tick) begin
                  if (w_timer_inc == TW'(REPEAT_DELAY)) begin
                     w_do_upd    = 1'b1;
                     w_state_nxt = ST_REPEAT;
                     w_timer_nxt = '0;
                  end else begin
                     w_timer_nxt = w_timer_inc;
                  end
               end
            end
            ST_REPEAT: begin
               if (!step_level) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_tick) begin
                  if (w_timer_inc == TW'(REPEAT_RATE)) begin
                     w_do_upd    = 1'b1;
                     w_timer_nxt = '0;
                  end else begin
                     w_timer_nxt = w_timer_inc;
                  end
               end
            end
            ST_RUN: begin
               if (w_tick) begin
                  if (w_timer_inc == TW'(RUN_RATE)) begin
                     w_do_upd    = 1'b1;
                     w_timer_nxt = '0;
                  end else begin
                     w_timer_nxt = w_timer_inc;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
         if (w_do_upd) begin
            w_count_nxt = w_upd_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
         r_timer <= '0;
         r_state <= ST_IDLE;
         r_count <= '0;
         r_upd   <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_presc <= w_tick ? '0 : (r_presc + PW'(1));
         r_timer <= w_timer_nxt;
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_upd   <= w_do_upd;
         r_wrap  <= w_do_upd & w_wrap;
      end
   end

   assign count     = r_count;
   assign upd_pulse = r_upd;
   assign wrap      = r_wrap;
   assign state     = r_state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: directed scenarios plus random traffic, scored
// against a cycle-level behavioural model of the counter's rules.
module tb_counter_seq_ctrl;

   localparam int W    = 4;
   localparam int TD   = 4;
   localparam int RD   = 3;
   localparam int RR   = 2;
   localparam int RUNR = 2;
   localparam int MODV = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         step_pulse = 1'b0;
   logic         step_level = 1'b0;
   logic         run_toggle = 1'b0;
   logic         clear = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         dir = 1'b0;
   logic [W-1:0] count;
   logic         upd_pulse;
   logic         wrap;
   logic [1:0]   state;

   counter_seq_ctrl #(
      .WIDTH(W), .TICK_DIV(TD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RUN_RATE(RUNR)
   ) dut (
      .clk(clk), .rst(rst), .step_pulse(step_pulse), .step_level(step_level),
      .run_toggle(run_toggle), .clear(clear), .load(load), .load_val(load_val),
      .dir(dir), .count(count), .upd_pulse(upd_pulse), .wrap(wrap), .state(state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // per-cycle expectation {count, upd, wrap, state}; per-update expectation {wrap, count}
   logic [W+3:0] exp_q[$];
   logic [W:0]   upd_q[$];

   // model state: mode 0 idle, 1 hold, 2 repeat, 3 run
   int m_count = 0;
   int m_mode  = 0;
   int m_ticks = 0;
   int m_edges = 0;
   logic g_lvl = 1'b0;
   logic g_dir = 1'b0;

   task automatic model_update(output bit wr);
      int nv;
      nv      = m_count + (dir ? -1 : 1);
      wr      = (nv < 0) || (nv >= MODV);
      m_count = (nv + MODV) % MODV;
   endtask

   task automatic model_step();
      bit tick;
      bit upd;
      bit wr;
      logic [W+3:0] e;
      upd  = 1'b0;
      wr   = 1'b0;
      tick = (m_edges % TD) == (TD - 1);
      if (rst) begin
         m_count = 0; m_mode = 0; m_ticks = 0; m_edges = 0;
      end else begin
         m_edges++;
         if (clear) begin
            m_count = 0; m_mode = 0; m_ticks = 0;
         end else if (load) begin
            m_count = int'(load_val);
         end else if (run_toggle) begin
            m_mode  = (m_mode == 3) ? 0 : 3;
            m_ticks = 0;
         end else if (m_mode == 0) begin
            if (step_pulse) begin
               model_update(wr); upd = 1'b1; m_mode = 1; m_ticks = 0;
            end
         end else if (m_mode == 1 || m_mode == 2) begin
            if (!step_level) m_mode = 0;
            else if (tick) begin
               m_ticks++;
               if (m_ticks == ((m_mode == 1) ? RD : RR)) begin
                  model_update(wr); upd = 1'b1; m_mode = 2; m_ticks = 0;
               end
            end
         end else if (tick) begin
            m_ticks++;
            if (m_ticks == RUNR) begin
               model_update(wr); upd = 1'b1; m_ticks = 0;
            end
         end
      end
      e = {W'(m_count), upd, wr, 2'(m_mode)};
      exp_q.push_back(e);
      if (upd) upd_q.push_back({wr, W'(m_count)});
   endtask

   task automatic drive(input bit r, input bit sp, input bit rt, input bit cl,
                        input bit ld, input logic [W-1:0] lv);
      @(negedge clk);
      rst = r; step_pulse = sp; run_toggle = rt; clear = cl; load = ld;
      load_val = lv; step_level = g_lvl; dir = g_dir;
      model_step();
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0);
   endtask

   task automatic chk(input string name, input int e_cnt, input int e_st,
                      input bit e_upd, input bit e_wr);
      #6;
      total++;
      if (count !== W'(e_cnt) || state !== 2'(e_st) || upd_pulse !== e_upd || wrap !== e_wr) begin
         bad++;
         $display("FAIL %s: got count=%h state=%0d upd=%b wrap=%b, want count=%h state=%0d upd=%b wrap=%b",
                  name, count, state, upd_pulse, wrap, W'(e_cnt), e_st, e_upd, e_wr);
      end
   endtask

   logic [W+3:0] mon_e, mon_a;
   logic [W:0]   mon_u;

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {count, upd_pulse, wrap, state};
         total++;
         if (mon_a !== mon_e) begin
            bad++;
            $display("FAIL cycle_out t=%0t got {count,upd,wrap,state}=%h want %h", $time, mon_a, mon_e);
         end
         if (upd_pulse === 1'b1) begin
            total++;
            if (upd_q.size() == 0) begin
               bad++;
               $display("FAIL upd_extra t=%0t got update count=%h want no update", $time, count);
            end else begin
               mon_u = upd_q.pop_front();
               if ({wrap, count} !== mon_u) begin
                  bad++;
                  $display("FAIL upd_value t=%0t got {wrap,count}=%h want %h", $time, {wrap, count}, mon_u);
               end
            end
         end
      end
   end

   initial begin
      // 1: reset then single step
      drive(1, 0, 0, 0, 0, '0);
      chk("reset", 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, '0);
      g_lvl = 1'b0;
      drive(0, 1, 0, 0, 0, '0);
      chk("first_step", 1, 1, 1, 0);
      idle_n(1);
      chk("step_release", 1, 0, 0, 0);

      // 2: hold to auto-repeat, then release
      g_lvl = 1'b1;
      drive(0, 1, 0, 0, 0, '0);
      idle_n(40);
      g_lvl = 1'b0;
      idle_n(3);

      // 3: wrap both ways
      drive(0, 0, 0, 0, 1, 4'hF);
      g_dir = 1'b0;
      drive(0, 1, 0, 0, 0, '0);
      chk("wrap_up", 0, 1, 1, 1);
      idle_n(1);
      g_dir = 1'b1;
      drive(0, 1, 0, 0, 0, '0);
      chk("wrap_down", 15, 1, 1, 1);
      idle_n(1);

      // 4: free-run, step ignored, toggle off
      g_dir = 1'b0;
      drive(0, 0, 1, 0, 0, '0);
      chk("run_enter", 15, 3, 0, 0);
      idle_n(20);
      g_lvl = 1'b1;
      drive(0, 1, 0, 0, 0, '0);
      idle_n(10);
      g_lvl = 1'b0;
      drive(0, 0, 1, 0, 0, '0);
      idle_n(3);

      // 5: clear beats load and run_toggle
      drive(0, 0, 1, 0, 0, '0);
      idle_n(5);
      drive(0, 0, 1, 1, 1, 4'd5);
      chk("priority", 0, 0, 0, 0);
      idle_n(2);

      // 6: reset in the middle of repeat
      g_lvl = 1'b1;
      drive(0, 1, 0, 0, 0, '0);
      idle_n(30);
      drive(1, 0, 0, 0, 0, '0);
      chk("reset_mid_repeat", 0, 0, 0, 0);
      g_lvl = 1'b0;
      idle_n(20);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit r, sp, rt, cl, ld;
         if ($urandom_range(0, 15) == 0) g_dir = ~g_dir;
         if ($urandom_range(0, 39) == 0) g_lvl = ~g_lvl;
         r  = ($urandom_range(0, 299) == 0);
         sp = ($urandom_range(0, 9) == 0);
         rt = ($urandom_range(0, 39) == 0);
         cl = ($urandom_range(0, 89) == 0);
         ld = ($urandom_range(0, 59) == 0);
         drive(r, sp, rt, cl, ld, W'($urandom_range(0, MODV - 1)));
      end

      @(posedge clk);
      #3;
      total++;
      if (exp_q.size() != 0 || upd_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d cycle and %0d update entries left, want 0 and 0",
                  exp_q.size(), upd_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
